// File: rtl/cfs_algn_pkg.sv
// Shared widths and field positions for the aligner's packed TX word.
// Word layout from LSB: data, then offset, then size in the MSBs.
package cfs_algn_pkg;

    function automatic int unsigned algn_offset_width(input int unsigned data_w);
        return (data_w > 8) ? $clog2(data_w / 8) : 1;
    endfunction

    // Size counts 1..bytes-per-word, so it needs one more bit than the offset.
    function automatic int unsigned algn_size_width(input int unsigned data_w);
        return $clog2(data_w / 8) + 1;
    endfunction

    function automatic int unsigned fifo_data_width(input int unsigned data_w);
        return data_w + algn_offset_width(data_w) + algn_size_width(data_w);
    endfunction

    function automatic int unsigned data_lsb(input int unsigned data_w);
        return (data_w > 0) ? 0 : 0;
    endfunction

    function automatic int unsigned data_msb(input int unsigned data_w);
        return data_w - 1;
    endfunction

    function automatic int unsigned offset_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned offset_msb(input int unsigned data_w);
        return data_w + algn_offset_width(data_w) - 1;
    endfunction

    function automatic int unsigned size_lsb(input int unsigned data_w);
        return data_w + algn_offset_width(data_w);
    endfunction

    function automatic int unsigned size_msb(input int unsigned data_w);
        return fifo_data_width(data_w) - 1;
    endfunction

    localparam int unsigned ALGN_DATA_WIDTH_DEF   = 32;
    localparam int unsigned ALGN_OFFSET_WIDTH_DEF = algn_offset_width(ALGN_DATA_WIDTH_DEF);
    localparam int unsigned ALGN_SIZE_WIDTH_DEF   = algn_size_width(ALGN_DATA_WIDTH_DEF);
    localparam int unsigned FIFO_DATA_WIDTH_DEF   = fifo_data_width(ALGN_DATA_WIDTH_DEF);

endpackage

// File: rtl/cfs_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered fill level.
// Optional synchronous clear port when CFS_TX_FIFO_CLR_EN is defined.
module cfs_sync_fifo #(
    parameter  int unsigned WIDTH = 37,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef CFS_TX_FIFO_CLR_EN
    input  logic             clr,
`endif
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready,
    output logic [CNT_W-1:0] fifo_lvl,
    output logic             fifo_full,
    output logic             fifo_empty
);

    localparam int unsigned IDX_W = CNT_W - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_lvl;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Handshake: a word moves on a rising edge only when valid and ready are
    // both high; ready never looks at the partner's valid, so push_ready and
    // pop_valid depend on registered state only.
    assign w_full   = (r_lvl == CNT_W'(DEPTH));
    assign w_empty  = (r_lvl == '0);
    assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_W-1:0];

`ifdef CFS_TX_FIFO_CLR_EN
    assign w_push = push_valid & ~w_full & ~clr;
    assign w_pop  = pop_ready & ~w_empty & ~clr;
`else
    assign w_push = push_valid & ~w_full;
    assign w_pop  = pop_ready & ~w_empty;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lvl    <= '0;
        end
`ifdef CFS_TX_FIFO_CLR_EN
        else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lvl    <= '0;
        end
`endif
        else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_lvl <= r_lvl + 1'b1;
                2'b01:   r_lvl <= r_lvl - 1'b1;
                default: r_lvl <= r_lvl;
            endcase
        end
    end

    // Storage is deliberately not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_idx] <= push_data;
    end

    assign push_ready = ~w_full;
    assign pop_valid  = ~w_empty;
    assign pop_data   = r_mem[w_rd_idx];
    assign fifo_lvl   = r_lvl;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;

endmodule

// File: rtl/cfs_tx_fifo.sv
// TX word FIFO between aligner core and TX controller; wraps cfs_sync_fifo.
// Defining CFS_TX_FIFO_CLR_EN adds a synchronous clear input 'clr'.
module cfs_tx_fifo
    import cfs_algn_pkg::*;
#(
    parameter  int unsigned ALGN_DATA_WIDTH = 32,
    parameter  int unsigned FIFO_DEPTH      = 8,
    localparam int unsigned FIFO_DATA_WIDTH = fifo_data_width(ALGN_DATA_WIDTH),
    localparam int unsigned CNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
`ifdef CFS_TX_FIFO_CLR_EN
    input  logic                       clr,
`endif
    input  logic                       push_valid,
    input  logic [FIFO_DATA_WIDTH-1:0] push_data,
    output logic                       push_ready,
    output logic                       pop_valid,
    output logic [FIFO_DATA_WIDTH-1:0] pop_data,
    input  logic                       pop_ready,
    output logic [CNT_WIDTH-1:0]       fifo_lvl,
    output logic                       fifo_full,
    output logic                       fifo_empty
);

    cfs_sync_fifo #(
        .WIDTH (FIFO_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef CFS_TX_FIFO_CLR_EN
        .clr        (clr),
`endif
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .fifo_lvl   (fifo_lvl),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

endmodule

// File: tb/tb_cfs_tx_fifo.sv
// Bench for cfs_tx_fifo (default 37-bit word, depth 8): vector table plus
// hand sequences for streaming, async reset and (if compiled in) clear.
module tb_cfs_tx_fifo;

    localparam int DW = 37;
    localparam int CW = 4;

    typedef struct {
        logic          push_valid;
        logic [DW-1:0] push_data;
        logic          pop_ready;
        logic [CW-1:0] lvl;
        logic          pop_valid;
        logic [DW-1:0] pop_data;
        logic          full;
        logic          empty;
    } vec_t;

    logic          clk;
    logic          reset_n;
    logic          clr;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_ready;
    logic [CW-1:0] fifo_lvl;
    logic          fifo_full;
    logic          fifo_empty;

    int errors;
    int checks;
    vec_t vecs[$];
    logic [DW-1:0] exp_q[$];

    cfs_tx_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef CFS_TX_FIFO_CLR_EN
        .clr        (clr),
`endif
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .fifo_lvl   (fifo_lvl),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkw(input int i);
        logic [2:0]  sz;
        logic [1:0]  off;
        logic [31:0] d;
        sz  = 3'(i % 5);
        off = 2'(i % 4);
        d   = 32'hC0DE_0000 + 32'(i);
        return {sz, off, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " lvl"},        64'(fifo_lvl),   64'd0);
        chk({tag, " empty"},      64'(fifo_empty), 64'd1);
        chk({tag, " full"},       64'(fifo_full),  64'd0);
        chk({tag, " push_ready"}, 64'(push_ready), 64'd1);
        chk({tag, " pop_valid"},  64'(pop_valid),  64'd0);
    endtask

    task automatic add(input logic pv, input logic [DW-1:0] pd, input logic pr,
                       input int lvl, input logic ov, input logic [DW-1:0] od,
                       input logic full, input logic empty);
        vec_t v;
        v.push_valid = pv;
        v.push_data  = pd;
        v.pop_ready  = pr;
        v.lvl        = CW'(lvl);
        v.pop_valid  = ov;
        v.pop_data   = od;
        v.full       = full;
        v.empty      = empty;
        vecs.push_back(v);
    endtask

    // Driver: one cycle of inputs, applied on the falling edge.
    task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pr);
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
    endtask

    initial begin
        logic [DW-1:0] w_a;
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        clr        = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        w_a        = {3'd0, 2'd1, 32'h1122_3344};

        // Single word in and out, then pop while empty
        add(1, w_a, 0, 1, 1, w_a, 0, 0);
        add(0, '0,  1, 0, 0, '0,  0, 1);
        add(0, '0,  1, 0, 0, '0,  0, 1);
        // Fill to full; head stays word 0; 9th push dropped
        for (int i = 0; i < 8; i++) add(1, mkw(i), 0, i + 1, 1, mkw(0), (i == 7), 0);
        add(1, mkw(8), 0, 8, 1, mkw(0), 1, 0);
        for (int j = 1; j <= 8; j++) add(0, '0, 1, 8 - j, (j < 8), (j < 8) ? mkw(j) : '0, 0, (j == 8));
        // Full with push+pop: pop only; word 24 must never appear
        for (int i = 0; i < 8; i++) add(1, mkw(16 + i), 0, i + 1, 1, mkw(16), (i == 7), 0);
        add(1, mkw(24), 1, 7, 1, mkw(17), 0, 0);
        for (int j = 1; j <= 7; j++) add(0, '0, 1, 7 - j, (j < 7), (j < 7) ? mkw(17 + j) : '0, 0, (j == 7));
        // Empty with push+pop: push only
        add(1, mkw(25), 1, 1, 1, mkw(25), 0, 0);
        add(0, '0,      1, 0, 0, '0,      0, 1);

        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset_held");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("after_reset");

        foreach (vecs[k]) begin
            drive(vecs[k].push_valid, vecs[k].push_data, vecs[k].pop_ready);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d lvl", k),        64'(fifo_lvl),   64'(vecs[k].lvl));
            chk($sformatf("v%0d pop_valid", k),  64'(pop_valid),  64'(vecs[k].pop_valid));
            chk($sformatf("v%0d full", k),       64'(fifo_full),  64'(vecs[k].full));
            chk($sformatf("v%0d empty", k),      64'(fifo_empty), 64'(vecs[k].empty));
            chk($sformatf("v%0d push_ready", k), 64'(push_ready), 64'(!vecs[k].full));
            if (vecs[k].pop_valid)
                chk($sformatf("v%0d pop_data", k), 64'(pop_data), 64'(vecs[k].pop_data));
        end

        // Streaming at level 4 across pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1, mkw(40 + i), 0);
            exp_q.push_back(mkw(40 + i));
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, mkw(44 + i), 1);
            #1;
            chk($sformatf("stream%0d data", i), 64'(pop_data), 64'(exp_q[0]));
            @(posedge clk);
            void'(exp_q.pop_front());
            exp_q.push_back(mkw(44 + i));
            #1;
            chk($sformatf("stream%0d lvl", i), 64'(fifo_lvl), 64'd4);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1);
            #1;
            chk($sformatf("drain%0d data", i), 64'(pop_data), 64'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        drive(0, '0, 0);
        @(posedge clk);
        #1;
        chk_idle("drained");

        // Asynchronous reset while holding 5 words
        for (int i = 0; i < 5; i++) drive(1, mkw(70 + i), 0);
        drive(0, '0, 0);
        @(posedge clk);
        #1;
        chk("pre_areset lvl", 64'(fifo_lvl), 64'd5);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle("areset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("areset_release");

`ifdef CFS_TX_FIFO_CLR_EN
        // Clear at level 5 with a concurrent push
        for (int i = 0; i < 5; i++) drive(1, mkw(80 + i), 0);
        drive(1, mkw(90), 1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("clr");
        drive(0, '0, 0);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("clr_after");
        drive(1, mkw(91), 0);
        @(posedge clk);
        #1;
        chk("clr_repush lvl",  64'(fifo_lvl), 64'd1);
        chk("clr_repush data", 64'(pop_data), 64'(mkw(91)));
        drive(0, '0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfs_tx_fifo.md
Name: cfs_tx_fifo

Overview:
Synchronous first-word-fall-through FIFO that buffers aligned TX words (data, offset and size packed) between the aligner core and the TX controller. The aligner core pushes into it. The TX controller pops from it with a valid/ready handshake, using pop_ready = pop_valid & md_tx_ready. It also exports the fill level for the status register.

Parameters:
- ALGN_DATA_WIDTH, 32, aligned data width in bits; power of 2, at least 8.
- FIFO_DEPTH, 8, number of entries; power of 2, at least 2.
- FIFO_DATA_WIDTH, derived (localparam), = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH.
  - Word layout: data in [DATA_W-1:0], then offset, then size in the MSBs.
- CNT_WIDTH, derived (localparam), = $clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- push_valid  in  1  upstream has a word.
- push_data  in  FIFO_DATA_WIDTH  packed word to store.
- push_ready  out  1  FIFO can accept a word.
- pop_valid  out  1  FIFO holds at least one word.
- pop_data  out  FIFO_DATA_WIDTH  head-of-FIFO word.
- pop_ready  in  1  downstream consumes the head word.
- fifo_lvl  out  CNT_WIDTH  number of stored words, 0..FIFO_DEPTH.
- fifo_full  out  1  fifo_lvl == FIFO_DEPTH.
- fifo_empty  out  1  fifo_lvl == 0.

Behaviour:
- Storage is a register array of FIFO_DEPTH x FIFO_DATA_WIDTH. The array is not reset.
- Pointers wr_ptr and rd_ptr are CNT_WIDTH wide; the extra MSB is a wrap bit.
  - Index = pointer[CNT_WIDTH-2:0].
  - Empty: wr_ptr == rd_ptr.
  - Full: indices equal and wrap bits differ.
  - Pointers wrap naturally modulo 2*FIFO_DEPTH.
- Push occurs when push_valid & push_ready: mem[wr_idx] <= push_data, wr_ptr += 1.
- Pop occurs when pop_valid & pop_ready: rd_ptr += 1.
- push_ready = !fifo_full, combinational from registered state only. It does not depend on pop_ready, so there is no comb path pop -> push.
- pop_valid = !fifo_empty. pop_data = mem[rd_idx], combinational (FWFT).
  - pop_data is don't-care while pop_valid = 0.
- Latency: a word pushed in cycle N appears on pop_valid/pop_data in cycle N+1. There is no empty-bypass.
- fifo_lvl is a registered counter: +1 on push only, -1 on pop only, unchanged on both or neither.
  - fifo_full and fifo_empty decode from fifo_lvl and must always agree with the pointers.
- Simultaneous push and pop:
  - Non-empty, non-full: both happen; level unchanged.
  - Full: only the pop happens (push_ready = 0); level becomes FIFO_DEPTH-1.
  - Empty: only the push happens (pop_valid = 0); level becomes 1.
- Once pop_valid = 1, it and pop_data stay stable until popped. Nothing removes a word except a pop, or a clear when the optional feature is compiled in.
- pop_ready asserted while empty, or push_valid asserted while full, is ignored with no state change.
- Reset values: wr_ptr = rd_ptr = 0, fifo_lvl = 0, fifo_empty = 1, fifo_full = 0, pop_valid = 0, push_ready = 1.
- Reset asserted mid-operation discards all contents immediately. Outputs go to their reset values asynchronously.

Optional Feature:
Macro CFS_TX_FIFO_CLR_EN.
- Defined:
  - Adds input port clr (1 bit, synchronous, active-high).
  - When clr = 1 on a clock edge: wr_ptr <= rd_ptr <= 0 and fifo_lvl <= 0.
  - A push or pop in the same cycle is ignored; clr has priority.
  - The next cycle shows pop_valid = 0 and push_ready = 1.
- Undefined: no clr port and no clear logic. Behaviour is otherwise identical.

Decomposition:
- Shared package cfs_algn_pkg holds:
  - Width functions/constants for ALGN_OFFSET_WIDTH, ALGN_SIZE_WIDTH and FIFO_DATA_WIDTH.
  - Field MSB/LSB positions of the packed word.
  - These are also used by the TX controller.
- The FIFO core is natural as a generic sub-module cfs_sync_fifo (parameters WIDTH and DEPTH). cfs_tx_fifo instantiates it and computes the widths.

Test Plan:
Defaults give FIFO_DATA_WIDTH = 37 and DEPTH = 8.
1. Reset -> fifo_lvl = 0, fifo_empty = 1, push_ready = 1, pop_valid = 0. Assert reset_n low while holding 5 words -> all outputs return to these values asynchronously.
2. Push 0x0_1_11223344 with pop_ready = 0 -> pop_valid = 1 the next cycle, pop_data equal to the pushed word, fifo_lvl = 1. Then pop_ready = 1 for one cycle -> empty.
3. Push 8 words without popping -> fifo_full = 1, push_ready = 0, fifo_lvl = 8. A 9th push is ignored. 8 pops return the words in order, with the wrap bit exercised.
4. Hold push_valid = pop_valid = pop_ready = 1 for 20 cycles at level 4 -> level stays 4 and the data order is preserved across pointer wrap.
5. Full FIFO with push and pop in the same cycle -> pop only, level 7. Empty FIFO with push and pop -> push only, level 1.
6. With CFS_TX_FIFO_CLR_EN: clr at level 5, pushing concurrently -> next cycle level 0, pop_valid = 0, and the concurrent push is lost.
